issue_ctrl: RTL and testbench



---
 rtl/issue_ctrl_pkg.sv | 22 ++
 rtl/issue_ctrl_if.sv | 45 ++++
 rtl/issue_ctrl_hazard_scoreboard.sv | 88 ++++++++
 rtl/issue_ctrl.sv | 116 +++++++++++
 tb/tb_issue_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : issue_ctrl_pkg
// Brief   : Shared types for the issue controller: register address, FSM states.
// Revision: 1.0
// ============================================================================
package issue_ctrl_pkg;

    localparam int c_REGADDR_W   = 5;
    localparam int c_ISSUE_ST_W  = 2;
    localparam int c_FLUSH_CNT_W = 3;

    typedef logic [c_REGADDR_W-1:0] regaddr_t;

    typedef enum logic [c_ISSUE_ST_W-1:0] {
        ST_RUN       = 2'd0,
        ST_WAIT_CTRL = 2'd1,
        ST_FLUSH     = 2'd2
    } issue_st_t;

endpackage
`default_nettype wire

// File: rtl/issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : issue_ctrl_if
// Brief   : Decoder/write-back/EX-resolve inputs and stall/flush/issue outputs.
// Revision: 1.0
// ============================================================================
interface issue_ctrl_if
    import issue_ctrl_pkg::*;
#(
    parameter int NREG = 32
);
    logic            rdy;
    logic            dec_valid;
    logic            dec_en_rx;
    logic            dec_en_ry;
    logic            dec_en_w;
    regaddr_t        dec_rx;
    regaddr_t        dec_ry;
    regaddr_t        dec_rd;
    logic            dec_is_load;
    logic            dec_is_ctrl;
    logic            wb_valid;
    regaddr_t        wb_rd;
    logic            ex_resolve;
    logic            ex_redirect;
    logic            issue;
    logic            stall_id;
    logic            stall_if;
    logic            flush_if;
    logic            flush_id;
    logic [NREG-1:0] busy_mask;

    modport master (
        output rdy, dec_valid, dec_en_rx, dec_en_ry, dec_en_w, dec_rx, dec_ry, dec_rd,
               dec_is_load, dec_is_ctrl, wb_valid, wb_rd, ex_resolve, ex_redirect,
        input  issue, stall_id, stall_if, flush_if, flush_id, busy_mask
    );

    modport slave (
        input  rdy, dec_valid, dec_en_rx, dec_en_ry, dec_en_w, dec_rx, dec_ry, dec_rd,
               dec_is_load, dec_is_ctrl, wb_valid, wb_rd, ex_resolve, ex_redirect,
        output issue, stall_id, stall_if, flush_if, flush_id, busy_mask
    );
endinterface
`default_nettype wire

// File: rtl/issue_ctrl_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : hazard_scoreboard
// Brief   : Per-register pending-write bits with wb bypass into the hazard check.
//           Option: ISSUE_FORWARD_EN adds a load mask so ALU RAW does not stall.
// Revision: 1.0
// ============================================================================
module hazard_scoreboard
    import issue_ctrl_pkg::*;
#(
    parameter int NREG = 32
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_en,
    input  wire logic            i_set,
    input  wire regaddr_t        i_set_rd,
`ifdef ISSUE_FORWARD_EN
    input  wire logic            i_set_ld,
`endif
    input  wire logic            i_clr,
    input  wire regaddr_t        i_clr_rd,
    input  wire logic            i_en_rx,
    input  wire regaddr_t        i_rx,
    input  wire logic            i_en_ry,
    input  wire regaddr_t        i_ry,
    input  wire logic            i_en_rd,
    input  wire regaddr_t        i_rd,
    output logic                 o_hazard,
    output logic [NREG-1:0]      o_busy_mask
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;
    logic [NREG-1:0] w_busy_eff;
    logic [NREG-1:0] w_src_mask;
    logic            w_rx_hit;
    logic            w_ry_hit;
    logic            w_rd_hit;

    // One-hot decode; bit 0 is never produced so x0 can never become busy.
    function automatic logic [NREG-1:0] f_dec(input regaddr_t a);
        f_dec = '0;
        for (int i = 1; i < NREG; i++) begin
            if (a == regaddr_t'(i)) f_dec[i] = 1'b1;
        end
    endfunction

`ifdef ISSUE_FORWARD_EN
    logic [NREG-1:0] r_ld;
    assign w_src_mask = w_busy_eff & r_ld;
`else
    assign w_src_mask = w_busy_eff;
`endif

    always_comb begin
        w_set_mask = i_set ? f_dec(i_set_rd) : '0;
        w_clr_mask = i_clr ? f_dec(i_clr_rd) : '0;
        w_busy_eff = r_busy & ~w_clr_mask;
        w_rx_hit   = |(f_dec(i_rx) & w_src_mask);
        w_ry_hit   = |(f_dec(i_ry) & w_src_mask);
        w_rd_hit   = |(f_dec(i_rd) & w_busy_eff);
        o_hazard   = (i_en_rx & w_rx_hit) | (i_en_ry & w_ry_hit) | (i_en_rd & w_rd_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else if (i_en) begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

`ifdef ISSUE_FORWARD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld <= '0;
        end else if (i_en) begin
            r_ld <= (r_ld & ~w_set_mask) | (w_set_mask & {NREG{i_set_ld}});
        end
    end
`endif

    assign o_busy_mask = r_busy;

endmodule
`default_nettype wire

// File: rtl/issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : issue_ctrl
// Brief   : Decode->execute issue control: hazard stall, control wait, flush.
//           Option: ISSUE_FORWARD_EN (ALU-result RAW hazards do not stall).
// Revision: 1.0
// ============================================================================
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int NREG         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  wire logic    clk,
    input  wire logic    rst,
    issue_ctrl_if.slave  bus
);

    localparam logic [c_FLUSH_CNT_W-1:0] c_FLUSH_INIT = c_FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [c_FLUSH_CNT_W-1:0] c_CNT_ONE    = c_FLUSH_CNT_W'(1);

    issue_st_t                r_state;
    logic [c_FLUSH_CNT_W-1:0] r_cnt;
    logic                     r_flush;
    logic                     w_hazard;
    logic                     w_issue;
    logic                     w_stall;
    logic [NREG-1:0]          w_busy_mask;

    hazard_scoreboard #(
        .NREG        (NREG)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .i_en        (bus.rdy),
        .i_set       (w_issue & bus.dec_en_w),
        .i_set_rd    (bus.dec_rd),
`ifdef ISSUE_FORWARD_EN
        .i_set_ld    (bus.dec_is_load),
`endif
        .i_clr       (bus.wb_valid),
        .i_clr_rd    (bus.wb_rd),
        .i_en_rx     (bus.dec_en_rx),
        .i_rx        (bus.dec_rx),
        .i_en_ry     (bus.dec_en_ry),
        .i_ry        (bus.dec_ry),
        .i_en_rd     (bus.dec_en_w),
        .i_rd        (bus.dec_rd),
        .o_hazard    (w_hazard),
        .o_busy_mask (w_busy_mask)
    );

    assign w_issue = ~rst & bus.rdy & (r_state == ST_RUN) & bus.dec_valid & ~w_hazard;

    // Priority: reset forces quiet outputs, then a frozen pipe holds IF/ID.
    always_comb begin
        w_stall = 1'b0;
        if (!rst) begin
            if (!bus.rdy) begin
                w_stall = 1'b1;
            end else begin
                case (r_state)
                    ST_RUN:       w_stall = bus.dec_valid & ~w_issue;
                    ST_WAIT_CTRL: w_stall = 1'b1;
                    default:      w_stall = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_flush <= 1'b0;
        end else if (bus.rdy) begin
            case (r_state)
                ST_RUN: begin
                    if (w_issue && bus.dec_is_ctrl) r_state <= ST_WAIT_CTRL;
                end
                ST_WAIT_CTRL: begin
                    if (bus.ex_resolve) begin
                        if (bus.ex_redirect) begin
                            r_state <= ST_FLUSH;
                            r_cnt   <= c_FLUSH_INIT;
                            r_flush <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RUN;
                        r_flush <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    assign bus.issue     = w_issue;
    assign bus.stall_id  = w_stall;
    assign bus.stall_if  = w_stall;
    assign bus.flush_if  = r_flush & ~rst;
    assign bus.flush_id  = r_flush & ~rst;
    assign bus.busy_mask = rst ? '0 : w_busy_mask;

endmodule
`default_nettype wire

// File: tb/tb_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_issue_ctrl
// Brief   : Scoreboard bench for issue_ctrl; expectations queued per driven cycle.
//           Covers both builds of ISSUE_FORWARD_EN.
// Revision: 1.0
// ============================================================================
module tb_issue_ctrl;

    typedef struct {
        string       tag;
        bit          issue;
        bit          stall;
        bit          flush;
        logic [31:0] busy;
    } exp_t;

    logic clk;
    logic rst;
    bit   r_done;
    int   n_tests;
    int   n_fail;
    int   n_pushed;
    int   n_popped;
    exp_t q_exp[$];

    issue_ctrl_if #(.NREG(32)) ifc ();

    issue_ctrl #(
        .NREG         (32),
        .FLUSH_CYCLES (2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] b(input int r);
        logic [31:0] one;
        one = 32'd1;
        return one << r;
    endfunction

    task automatic t_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic inst(input bit v, input bit erx, input int rx, input bit ery, input int ry,
                        input bit ew, input int rd, input bit ld, input bit ctl);
        ifc.dec_valid   = v;
        ifc.dec_en_rx   = erx;
        ifc.dec_rx      = 5'(rx);
        ifc.dec_en_ry   = ery;
        ifc.dec_ry      = 5'(ry);
        ifc.dec_en_w    = ew;
        ifc.dec_rd      = 5'(rd);
        ifc.dec_is_load = ld;
        ifc.dec_is_ctrl = ctl;
    endtask

    task automatic ctl(input bit rdy, input bit wbv, input int wbrd, input bit res, input bit red);
        ifc.rdy         = rdy;
        ifc.wb_valid    = wbv;
        ifc.wb_rd       = 5'(wbrd);
        ifc.ex_resolve  = res;
        ifc.ex_redirect = red;
    endtask

    task automatic idle();
        inst(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Queue the expectation for the cycle just driven, then move to the next one.
    task automatic cyc(input string tag, input bit iss, input bit stl, input bit fl,
                       input logic [31:0] busy);
        exp_t e;
        e.tag   = tag;
        e.issue = iss;
        e.stall = stl;
        e.flush = fl;
        e.busy  = busy;
        q_exp.push_back(e);
        n_pushed++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                n_popped++;
                t_check({e.tag, ".issue"},    32'(ifc.issue),    32'(e.issue));
                t_check({e.tag, ".stall_id"}, 32'(ifc.stall_id), 32'(e.stall));
                t_check({e.tag, ".stall_if"}, 32'(ifc.stall_if), 32'(e.stall));
                t_check({e.tag, ".flush_if"}, 32'(ifc.flush_if), 32'(e.flush));
                t_check({e.tag, ".flush_id"}, 32'(ifc.flush_id), 32'(e.flush));
                t_check({e.tag, ".busy"},     ifc.busy_mask,     e.busy);
            end else if (r_done) begin
                t_check("drain", 32'(n_popped), 32'(n_pushed));
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        r_done   = 1'b0;
        n_tests  = 0;
        n_fail   = 0;
        n_pushed = 0;
        n_popped = 0;
        rst      = 1'b1;
        ctl(1, 0, 0, 0, 0);
        inst(1, 1, 1, 1, 2, 1, 5, 0, 0);
        @(posedge clk);
        #1;
        cyc("rst0", 0, 0, 0, 32'h0);
        cyc("rst1", 0, 0, 0, 32'h0);
        rst = 1'b0;
        cyc("add_x5", 1, 0, 0, 32'h0);
`ifndef ISSUE_FORWARD_EN
        inst(1, 1, 5, 1, 1, 1, 6, 0, 0);
        cyc("raw_x5", 0, 1, 0, b(5));
        ctl(1, 1, 5, 0, 0);
        cyc("raw_wb", 1, 0, 0, b(5));
        inst(1, 1, 6, 0, 0, 1, 6, 0, 0);
        ctl(1, 1, 6, 0, 0);
        cyc("set_wins", 1, 0, 0, b(6));
        idle();
        ctl(1, 0, 0, 0, 0);
        cyc("set_kept", 0, 0, 0, b(6));
        inst(1, 0, 0, 0, 0, 1, 6, 0, 0);
        cyc("waw", 0, 1, 0, b(6));
        inst(1, 1, 0, 0, 0, 1, 0, 0, 0);
        ctl(1, 1, 6, 0, 0);
        cyc("x0", 1, 0, 0, b(6));
`else
        inst(1, 1, 5, 1, 2, 1, 7, 0, 0);
        cyc("fwd_alu", 1, 0, 0, b(5));
        inst(1, 1, 1, 0, 0, 1, 8, 1, 0);
        cyc("lw_x8", 1, 0, 0, b(5) | b(7));
        inst(1, 1, 8, 1, 1, 1, 9, 0, 0);
        cyc("ld_raw0", 0, 1, 0, b(5) | b(7) | b(8));
        cyc("ld_raw1", 0, 1, 0, b(5) | b(7) | b(8));
        ctl(1, 1, 8, 0, 0);
        cyc("ld_wb", 1, 0, 0, b(5) | b(7) | b(8));
        ctl(1, 0, 0, 0, 0);
        inst(1, 0, 0, 0, 0, 1, 5, 0, 0);
        cyc("waw", 0, 1, 0, b(5) | b(7) | b(9));
        idle();
        ctl(1, 1, 5, 0, 0);
        cyc("drain5", 0, 0, 0, b(5) | b(7) | b(9));
        ctl(1, 1, 7, 0, 0);
        cyc("drain7", 0, 0, 0, b(7) | b(9));
        ctl(1, 1, 9, 0, 0);
        cyc("drain9", 0, 0, 0, b(9));
`endif
        idle();
        ctl(1, 0, 0, 1, 1);
        cyc("res_ignored", 0, 0, 0, 32'h0);
        inst(1, 1, 1, 1, 2, 0, 0, 0, 1);
        ctl(1, 0, 0, 0, 0);
        cyc("beq", 1, 0, 0, 32'h0);
        inst(1, 1, 1, 0, 0, 1, 3, 0, 0);
        cyc("wait0", 0, 1, 0, 32'h0);
        cyc("wait1", 0, 1, 0, 32'h0);
        ctl(1, 0, 0, 1, 1);
        cyc("resolve", 0, 1, 0, 32'h0);
        ctl(1, 0, 0, 0, 0);
        cyc("flush0", 0, 0, 1, 32'h0);
        cyc("flush1", 0, 0, 1, 32'h0);
        cyc("add_x3", 1, 0, 0, 32'h0);
        inst(1, 1, 1, 1, 2, 0, 0, 0, 1);
        ctl(1, 1, 3, 0, 0);
        cyc("beq2", 1, 0, 0, b(3));
        inst(1, 1, 1, 0, 0, 1, 4, 0, 0);
        ctl(1, 0, 0, 1, 0);
        cyc("res_noredir", 0, 1, 0, 32'h0);
        ctl(1, 0, 0, 0, 0);
        cyc("add_x4", 1, 0, 0, 32'h0);
        inst(1, 1, 1, 0, 0, 0, 0, 0, 1);
        cyc("beq3", 1, 0, 0, b(4));
        idle();
        ctl(1, 0, 0, 1, 1);
        cyc("resolve3", 0, 1, 0, b(4));
        inst(1, 1, 1, 0, 0, 1, 9, 0, 0);
        ctl(0, 1, 4, 0, 0);
        cyc("rdy0_a", 0, 1, 1, b(4));
        cyc("rdy0_b", 0, 1, 1, b(4));
        idle();
        ctl(1, 0, 0, 0, 0);
        cyc("flush_hold", 0, 0, 1, b(4));
        cyc("flush_last", 0, 0, 1, b(4));
        cyc("run_again", 0, 0, 0, b(4));
        inst(1, 1, 1, 0, 0, 0, 0, 0, 1);
        cyc("beq4", 1, 0, 0, b(4));
        inst(1, 1, 4, 0, 0, 1, 9, 0, 0);
        cyc("wait4", 0, 1, 0, b(4));
        rst = 1'b1;
        cyc("rst_mid", 0, 0, 0, 32'h0);
        rst = 1'b0;
        cyc("after_rst", 1, 0, 0, 32'h0);
        idle();
        cyc("busy_x9", 0, 0, 0, b(9));
        inst(1, 1, 1, 0, 0, 1, 10, 0, 0);
        ctl(0, 0, 0, 0, 0);
        cyc("rdy0_run", 0, 1, 0, b(9));
        idle();
        ctl(1, 0, 0, 0, 0);
        cyc("end", 0, 0, 0, b(9));
        r_done = 1'b1;
    end

endmodule
`default_nettype wire
